// File: rtl/reg_wb_arbiter_pkg.sv
// Shared types for the writeback arbiter: register/data widths and the slot payload.
// The top's DATA_W/ADDR_W parameters must match XLEN/REG_ADDR_W.
package reg_wb_arbiter_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int XLEN       = 32;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic [XLEN-1:0]       data;
  } wb_req_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: one-hot grant to the first set request
// found searching upward from ptr, wrapping from N-1 back to 0.
module rr_arbiter #(
  parameter int N = 3,
  localparam int PTR_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     grant
);

  always_comb begin
    logic             found;
    logic [PTR_W-1:0] idx;
    // NOTE: every variable written here gets a default first so no latch is inferred.
    grant = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < N; k++) begin
      idx = PTR_W'((int'(ptr) + k) % N);
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/reg_wb_arbiter.sv
// Register-file writeback arbiter: per-source holding slots, round-robin drain into a
// registered write stage, and a RAW pending scoreboard. Optional forwarding: WB_FORWARD_EN.
module reg_wb_arbiter
  import reg_wb_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int DATA_W  = XLEN,
  parameter int ADDR_W  = REG_ADDR_W
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic                      wb_en,
  output logic [ADDR_W-1:0]         wb_addr,
  output logic [DATA_W-1:0]         write_data,
  input  logic [ADDR_W-1:0]         rs1_addr,
  input  logic [ADDR_W-1:0]         rs2_addr,
  output logic                      rs1_pending,
`ifdef WB_FORWARD_EN
  output logic                      rs2_pending,
  output logic                      rs1_fwd_hit,
  output logic                      rs2_fwd_hit,
  output logic [DATA_W-1:0]         rs1_fwd_data,
  output logic [DATA_W-1:0]         rs2_fwd_data
`else
  output logic                      rs2_pending
`endif
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0] r_full;
  wb_req_t            r_slot [NUM_REQ];
  logic [PTR_W-1:0]   r_rr_ptr;
  logic               r_wb_en;
  logic [ADDR_W-1:0]  r_wb_addr;
  logic [DATA_W-1:0]  r_wb_data;

  logic [NUM_REQ-1:0] w_grant;
  logic [NUM_REQ-1:0] w_accept;
  logic [NUM_REQ-1:0] w_load;
  logic               w_any_grant;
  wb_req_t            w_grant_req;
  logic [PTR_W-1:0]   w_grant_idx;
  logic [PTR_W-1:0]   w_next_ptr;
  logic [ADDR_W-1:0]  w_rs_addr [2];
  logic [1:0]         w_rs_pending;

  rr_arbiter #(.N(NUM_REQ)) u_rr_arbiter (
    .req   (r_full),
    .ptr   (r_rr_ptr),
    .grant (w_grant)
  );

  // A slot being drained this cycle can take a new write in the same cycle.
  assign req_ready = ~r_full | w_grant;
  assign w_accept  = req_valid & req_ready;

  // Writes to x0 complete the handshake but never occupy a slot.
  always_comb begin
    w_load = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_load[i] = w_accept[i] && (req_addr[i*ADDR_W +: ADDR_W] != '0);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_full <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (w_accept[i]) begin
          r_full[i] <= w_load[i];
        end else if (w_grant[i]) begin
          r_full[i] <= 1'b0;
        end
      end
    end
  end

  // NOTE: slot payload is not reset; the full bit alone decides whether it is meaningful.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_load[i]) begin
        r_slot[i].addr <= req_addr[i*ADDR_W +: ADDR_W];
        r_slot[i].data <= req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    w_grant_req = '0;
    w_grant_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_grant[i]) begin
        w_grant_req = r_slot[i];
        w_grant_idx = PTR_W'(i);
      end
    end
  end

  assign w_any_grant = |w_grant;
  assign w_next_ptr  = (w_grant_idx == PTR_W'(NUM_REQ - 1)) ? '0 : w_grant_idx + PTR_W'(1);

  // Output stage: address/data hold when idle so the register file sees stable values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wb_en   <= 1'b0;
      r_wb_addr <= '0;
      r_wb_data <= '0;
      r_rr_ptr  <= '0;
    end else if (w_any_grant) begin
      r_wb_en   <= 1'b1;
      r_wb_addr <= w_grant_req.addr;
      r_wb_data <= w_grant_req.data;
      r_rr_ptr  <= w_next_ptr;
    end else begin
      r_wb_en   <= 1'b0;
    end
  end

  assign wb_en      = r_wb_en;
  assign wb_addr    = r_wb_addr;
  assign write_data = r_wb_data;

  assign w_rs_addr[0] = rs1_addr;
  assign w_rs_addr[1] = rs2_addr;

  // A source is pending while its register sits in any slot or in the output stage.
  always_comb begin
    w_rs_pending = '0;
    for (int s = 0; s < 2; s++) begin
      if (w_rs_addr[s] != '0) begin
        if (r_wb_en && (r_wb_addr == w_rs_addr[s])) begin
          w_rs_pending[s] = 1'b1;
        end
        for (int i = 0; i < NUM_REQ; i++) begin
          if (r_full[i] && (r_slot[i].addr == w_rs_addr[s])) begin
            w_rs_pending[s] = 1'b1;
          end
        end
      end
    end
  end

  assign rs1_pending = w_rs_pending[0];
  assign rs2_pending = w_rs_pending[1];

`ifdef WB_FORWARD_EN
  assign rs1_fwd_hit  = r_wb_en && (r_wb_addr == rs1_addr) && (rs1_addr != '0);
  assign rs2_fwd_hit  = r_wb_en && (r_wb_addr == rs2_addr) && (rs2_addr != '0);
  assign rs1_fwd_data = r_wb_data;
  assign rs2_fwd_data = r_wb_data;
`endif

endmodule

// File: tb/tb_reg_wb_arbiter.sv
// Directed bench for reg_wb_arbiter: per-cycle vector table plus hand-written reset
// and (with WB_FORWARD_EN) forwarding sequences.
module tb_reg_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  req_valid;
  logic [2:0]  req_ready;
  logic [14:0] req_addr;
  logic [95:0] req_data;
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [31:0] write_data;
  logic [4:0]  rs1_addr;
  logic [4:0]  rs2_addr;
  logic        rs1_pending;
  logic        rs2_pending;
`ifdef WB_FORWARD_EN
  logic        rs1_fwd_hit;
  logic        rs2_fwd_hit;
  logic [31:0] rs1_fwd_data;
  logic [31:0] rs2_fwd_data;
`endif

  int n_checks = 0;
  int n_errors = 0;

  reg_wb_arbiter #(.NUM_REQ(3), .DATA_W(32), .ADDR_W(5)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_addr    (req_addr),
    .req_data    (req_data),
    .wb_en       (wb_en),
    .wb_addr     (wb_addr),
    .write_data  (write_data),
    .rs1_addr    (rs1_addr),
    .rs2_addr    (rs2_addr),
    .rs1_pending (rs1_pending),
`ifdef WB_FORWARD_EN
    .rs2_pending (rs2_pending),
    .rs1_fwd_hit (rs1_fwd_hit),
    .rs2_fwd_hit (rs2_fwd_hit),
    .rs1_fwd_data(rs1_fwd_data),
    .rs2_fwd_data(rs2_fwd_data)
`else
    .rs2_pending (rs2_pending)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  valid;
    logic [4:0]  a0, a1, a2;
    logic [31:0] d0, d1, d2;
    logic [4:0]  rs1, rs2;
    logic [2:0]  e_ready;
    logic        e_en;
    logic [4:0]  e_addr;
    logic [31:0] e_data;
    logic        e_p1, e_p2;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic [2:0] valid,
                              input logic [4:0] a0, input logic [31:0] d0,
                              input logic [4:0] a1, input logic [31:0] d1,
                              input logic [4:0] a2, input logic [31:0] d2,
                              input logic [4:0] rs1, input logic [4:0] rs2,
                              input logic [2:0] e_ready, input logic e_en,
                              input logic [4:0] e_addr, input logic [31:0] e_data,
                              input logic e_p1, input logic e_p2);
    vec_t v;
    v.valid = valid; v.a0 = a0; v.d0 = d0; v.a1 = a1; v.d1 = d1; v.a2 = a2; v.d2 = d2;
    v.rs1 = rs1; v.rs2 = rs2; v.e_ready = e_ready; v.e_en = e_en;
    v.e_addr = e_addr; v.e_data = e_data; v.e_p1 = e_p1; v.e_p2 = e_p2;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [2:0] valid,
                       input logic [4:0] a0, input logic [31:0] d0,
                       input logic [4:0] a1, input logic [31:0] d1,
                       input logic [4:0] a2, input logic [31:0] d2);
    req_valid = valid;
    req_addr  = {a2, a1, a0};
    req_data  = {d2, d1, d0};
  endtask

  // Drive on the falling edge, compare 1 ns later, well before the next rising edge.
  task automatic apply_vec(input vec_t v, input int idx);
    @(negedge clk);
    drive(v.valid, v.a0, v.d0, v.a1, v.d1, v.a2, v.d2);
    rs1_addr = v.rs1;
    rs2_addr = v.rs2;
    #1;
    check($sformatf("v%0d.req_ready", idx), 64'(req_ready), 64'(v.e_ready));
    check($sformatf("v%0d.wb_en", idx), 64'(wb_en), 64'(v.e_en));
    check($sformatf("v%0d.wb_addr", idx), 64'(wb_addr), 64'(v.e_addr));
    check($sformatf("v%0d.write_data", idx), 64'(write_data), 64'(v.e_data));
    check($sformatf("v%0d.rs1_pending", idx), 64'(rs1_pending), 64'(v.e_p1));
    check($sformatf("v%0d.rs2_pending", idx), 64'(rs2_pending), 64'(v.e_p2));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    drive(3'b000, 5'd0, 32'h0, 5'd0, 32'h0, 5'd0, 32'h0);
    rs1_addr = '0;
    rs2_addr = '0;
    repeat (2) @(negedge clk);
    #1;
    check("reset.wb_en", 64'(wb_en), 64'd0);
    check("reset.wb_addr", 64'(wb_addr), 64'd0);
    check("reset.write_data", 64'(write_data), 64'd0);
    check("reset.req_ready", 64'(req_ready), 64'h7);
    @(negedge clk);
    rst = 1'b0;

    // Contention from rr_ptr=0: x1, x2, x3 on consecutive cycles.
    tbl.push_back(mk(3'b111, 5'd1, 32'd1, 5'd2, 32'd2, 5'd3, 32'd3, 5'd3, 5'd1, 3'b111, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0));
    tbl.push_back(mk(3'b000, 5'd0, 32'd0, 5'd0, 32'd0, 5'd0, 32'd0, 5'd3, 5'd1, 3'b001, 1'b0, 5'd0, 32'd0, 1'b1, 1'b1));
    tbl.push_back(mk(3'b000, 5'd0, 32'd0, 5'd0, 32'd0, 5'd0, 32'd0, 5'd3, 5'd1, 3'b011, 1'b1, 5'd1, 32'd1, 1'b1, 1'b1));
    tbl.push_back(mk(3'b000, 5'd0, 32'd0, 5'd0, 32'd0, 5'd0, 32'd0, 5'd3, 5'd1, 3'b111, 1'b1, 5'd2, 32'd2, 1'b1, 1'b0));
    tbl.push_back(mk(3'b000, 5'd0, 32'd0, 5'd0, 32'd0, 5'd0, 32'd0, 5'd3, 5'd1, 3'b111, 1'b1, 5'd3, 32'd3, 1'b1, 1'b0));
    tbl.push_back(mk(3'b000, 5'd0, 32'd0, 5'd0, 32'd0, 5'd0, 32'd0, 5'd3, 5'd1, 3'b111, 1'b0, 5'd3, 32'd3, 1'b0, 1'b0));
    // Fairness: 0 and 2 stream, 1 joins once; first grant to 0 shows rr_ptr returned to 0.
    tbl.push_back(mk(3'b101, 5'd10, 32'h100, 5'd0, 32'h0, 5'd12, 32'h300, 5'd11, 5'd0, 3'b111, 1'b0, 5'd3, 32'd3, 1'b0, 1'b0));
    tbl.push_back(mk(3'b101, 5'd10, 32'h100, 5'd0, 32'h0, 5'd12, 32'h300, 5'd11, 5'd0, 3'b011, 1'b0, 5'd3, 32'd3, 1'b0, 1'b0));
    tbl.push_back(mk(3'b101, 5'd10, 32'h100, 5'd0, 32'h0, 5'd12, 32'h300, 5'd11, 5'd0, 3'b110, 1'b1, 5'd10, 32'h100, 1'b0, 1'b0));
    tbl.push_back(mk(3'b111, 5'd10, 32'h100, 5'd11, 32'h200, 5'd12, 32'h300, 5'd11, 5'd0, 3'b011, 1'b1, 5'd12, 32'h300, 1'b0, 1'b0));
    tbl.push_back(mk(3'b101, 5'd10, 32'h100, 5'd0, 32'h0, 5'd12, 32'h300, 5'd11, 5'd0, 3'b010, 1'b1, 5'd10, 32'h100, 1'b1, 1'b0));
    tbl.push_back(mk(3'b101, 5'd10, 32'h100, 5'd0, 32'h0, 5'd12, 32'h300, 5'd11, 5'd0, 3'b110, 1'b1, 5'd11, 32'h200, 1'b1, 1'b0));
    tbl.push_back(mk(3'b000, 5'd0, 32'h0, 5'd0, 32'h0, 5'd0, 32'h0, 5'd11, 5'd0, 3'b011, 1'b1, 5'd12, 32'h300, 1'b0, 1'b0));
    tbl.push_back(mk(3'b000, 5'd0, 32'h0, 5'd0, 32'h0, 5'd0, 32'h0, 5'd11, 5'd0, 3'b111, 1'b1, 5'd10, 32'h100, 1'b0, 1'b0));
    tbl.push_back(mk(3'b000, 5'd0, 32'h0, 5'd0, 32'h0, 5'd0, 32'h0, 5'd11, 5'd0, 3'b111, 1'b1, 5'd12, 32'h300, 1'b0, 1'b0));
    tbl.push_back(mk(3'b000, 5'd0, 32'h0, 5'd0, 32'h0, 5'd0, 32'h0, 5'd11, 5'd0, 3'b111, 1'b0, 5'd12, 32'h300, 1'b0, 1'b0));
    // Single write x5 from requester 0: pending spans accept edge to two edges later.
    tbl.push_back(mk(3'b001, 5'd5, 32'hDEADBEEF, 5'd0, 32'h0, 5'd0, 32'h0, 5'd5, 5'd0, 3'b111, 1'b0, 5'd12, 32'h300, 1'b0, 1'b0));
    tbl.push_back(mk(3'b000, 5'd0, 32'h0, 5'd0, 32'h0, 5'd0, 32'h0, 5'd5, 5'd0, 3'b111, 1'b0, 5'd12, 32'h300, 1'b1, 1'b0));
    tbl.push_back(mk(3'b000, 5'd0, 32'h0, 5'd0, 32'h0, 5'd0, 32'h0, 5'd5, 5'd0, 3'b111, 1'b1, 5'd5, 32'hDEADBEEF, 1'b1, 1'b0));
    tbl.push_back(mk(3'b000, 5'd0, 32'h0, 5'd0, 32'h0, 5'd0, 32'h0, 5'd5, 5'd0, 3'b111, 1'b0, 5'd5, 32'hDEADBEEF, 1'b0, 1'b0));
    // x0 write from requester 1: accepted, never issued, never pending.
    tbl.push_back(mk(3'b010, 5'd0, 32'h0, 5'd0, 32'h1234, 5'd0, 32'h0, 5'd0, 5'd0, 3'b111, 1'b0, 5'd5, 32'hDEADBEEF, 1'b0, 1'b0));
    tbl.push_back(mk(3'b000, 5'd0, 32'h0, 5'd0, 32'h0, 5'd0, 32'h0, 5'd0, 5'd0, 3'b111, 1'b0, 5'd5, 32'hDEADBEEF, 1'b0, 1'b0));
    tbl.push_back(mk(3'b000, 5'd0, 32'h0, 5'd0, 32'h0, 5'd0, 32'h0, 5'd0, 5'd0, 3'b111, 1'b0, 5'd5, 32'hDEADBEEF, 1'b0, 1'b0));

    foreach (tbl[i]) apply_vec(tbl[i], i);

    // Reset mid-stream: rr_ptr=1, so x4 (slot 1) issues first while x5/x6 stay held.
    @(negedge clk);
    drive(3'b111, 5'd5, 32'h55, 5'd4, 32'h44, 5'd6, 32'h66);
    rs1_addr = 5'd5;
    rs2_addr = 5'd6;
    @(negedge clk);
    drive(3'b000, 5'd0, 32'h0, 5'd0, 32'h0, 5'd0, 32'h0);
    #1;
    check("rst_seq.ready_serialized", 64'(req_ready), 64'h2);
    @(negedge clk);
    #1;
    check("rst_seq.wb_en_before", 64'(wb_en), 64'd1);
    check("rst_seq.wb_addr_before", 64'(wb_addr), 64'd4);
    check("rst_seq.rs1_pending_before", 64'(rs1_pending), 64'd1);
    check("rst_seq.rs2_pending_before", 64'(rs2_pending), 64'd1);
    rst = 1'b1;
    #1;
    check("rst_seq.wb_en_async", 64'(wb_en), 64'd0);
    check("rst_seq.wb_addr_async", 64'(wb_addr), 64'd0);
    check("rst_seq.rs1_pending_async", 64'(rs1_pending), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      #1;
      check($sformatf("rst_seq.c%0d.wb_en", c), 64'(wb_en), 64'd0);
      check($sformatf("rst_seq.c%0d.req_ready", c), 64'(req_ready), 64'h7);
      check($sformatf("rst_seq.c%0d.rs2_pending", c), 64'(rs2_pending), 64'd0);
    end

`ifdef WB_FORWARD_EN
    @(negedge clk);
    drive(3'b010, 5'd0, 32'h0, 5'd7, 32'h55, 5'd0, 32'h0);
    rs1_addr = 5'd0;
    rs2_addr = 5'd7;
    @(negedge clk);
    drive(3'b000, 5'd0, 32'h0, 5'd0, 32'h0, 5'd0, 32'h0);
    #1;
    check("fwd.hit_early", 64'(rs2_fwd_hit), 64'd0);
    check("fwd.pending_early", 64'(rs2_pending), 64'd1);
    @(negedge clk);
    #1;
    check("fwd.rs2_hit", 64'(rs2_fwd_hit), 64'd1);
    check("fwd.rs2_data", 64'(rs2_fwd_data), 64'h55);
    check("fwd.rs2_pending", 64'(rs2_pending), 64'd1);
    check("fwd.rs1_x0_hit", 64'(rs1_fwd_hit), 64'd0);
`endif

    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
